pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register that replaces the fixed, always-advancing stage latches between decode/execute, execute/memory and memory/writeback. It carries an opaque payload bundle with a valid/ready handshake, and optionally a two-entry skid buffer so that back-pressure does not create a combinational ready path. It also supports a synchronous flush and emits a defined NOP payload whenever no valid instruction is presented. A saturating stall counter supports performance debug.

## Interface
Parameters:
- DATA_W, default 81: payload width (aluop 8 + alusel 3 + reg1 32 + reg2 32 + wd 5 + wreg 1).
- NOP_VALUE, default all-zero DATA_W: payload driven whenever out_valid=0, including after reset and flush.
- SKID, default 1: 1 selects the two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
- CNT_W, default 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous discard of all held entries (branch or exception).
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload is valid.
- out_ready  in  1  downstream consumes the payload this cycle.
- out_data  out  DATA_W  held payload, or NOP_VALUE when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
Transfer rules:
- An accept occurs when in_valid && in_ready.
- A consume occurs when out_valid && out_ready.
- Order is preserved. There is no loss or duplication except on flush or rst.

SKID=1 state machine:
- States are EMPTY (main empty), ONE (main full, skid empty) and FULL (main full, skid full).
- in_ready = (state != FULL). It is driven from a flop only.
- EMPTY: an accept loads main and moves to ONE.
- ONE with accept and consume: main reloads from in_data; stay in ONE.
- ONE with accept and no consume: skid loads from in_data; move to FULL.
- ONE with consume and no accept: move to EMPTY.
- FULL with consume: main takes skid; move to ONE. No accept is possible in FULL.

SKID=0:
- Only EMPTY and ONE exist.
- in_ready = !out_valid || out_ready (combinational).

Flush and reset:
- flush=1 forces EMPTY. out_data becomes NOP_VALUE on the next cycle.
- Any accept in the flush cycle is dropped, and any consume in that cycle is still honoured by downstream.
- stall_cnt is unaffected by flush.
- rst=1 has the same effect as flush, also clears stall_cnt to 0, and takes priority over flush.

stall_cnt:
- Increments on each cycle with out_valid && !out_ready.
- Holds at 2^CNT_W-1; it does not wrap.

## Timing
- Reset values: out_valid=0, out_data=NOP_VALUE, stall_cnt=0, state=EMPTY. in_ready=1 in both modes.
- Latency: 1 cycle. A payload accepted at edge N is visible on out_data after edge N.
- Throughput: 1 payload per cycle with out_ready held at 1, in both modes.
- SKID=1: in_ready falls one cycle after the stall begins. Up to 2 payloads are held.
- out_data changes only on an edge: on a load, a skid-to-main move, a flush, or reset.
- out_data is stable while out_valid && !out_ready.
- Simultaneous flush and a consume of the same entry counts as consumed. The entry is not re-presented.

## Structure
- Package pipe_pkg holds:
  - the stage payload struct width constants (AluOp/AluSel/Reg/RegAddr widths);
  - the NOP payload constants (EXE_NOP_OP, EXE_RES_NOP, ZeroWord, NOPRegAddr, WriteDisable);
  - the state encoding localparams EMPTY/ONE/FULL.
- Sub-module sat_counter (parameter CNT_W; ports clk, rst, inc, count) implements stall_cnt.
- Both SKID variants are selected with a generate on SKID inside this module.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 and in_data=0x1_2345. Require out_valid=0, out_data=NOP_VALUE, in_ready=1 and stall_cnt=0 after release.
- Streaming: out_ready=1 and 8 back-to-back payloads 0x01..0x08. Require outputs 0x01..0x08 on consecutive cycles, each 1 cycle after its accept, in_ready constantly 1, in both SKID modes.
- Back-pressure, SKID=1: accept A, B, C with out_ready=0 from the cycle after A.
  - Require in_ready=0 after B is captured, and C held upstream.
  - stall_cnt counts each stalled cycle.
  - On releasing out_ready, require the order A, B, C with no gap.
- Flush in FULL: flush=1 with in_valid=1 and D presented. Require out_valid=0 and out_data=NOP_VALUE next cycle, D not delivered, and stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid held 1 with out_ready=0 for 20 cycles. Require stall_cnt=15 and no wrap.
- Priority: rst and flush asserted together mid-stall. Require all reset values, including stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared stage-payload layout, NOP payload constants and stage-register state encoding.
// Pure declarations; no logic and no latency.
// No backpressure behaviour of its own.
package pipe_pkg;

    // Field widths of the inter-stage payload bundle
    localparam int AluOpBusW   = 8;
    localparam int AluSelBusW  = 3;
    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;
    localparam int STAGE_W     = AluOpBusW + AluSelBusW + 2 * RegBusW + RegAddrBusW + 1;

    // Field values that make up a bubble: no operation, no register write
    localparam logic [AluOpBusW-1:0]   EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [AluSelBusW-1:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [RegBusW-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [RegAddrBusW-1:0] NOPRegAddr   = 5'b00000;
    localparam logic                   WriteDisable = 1'b0;

    typedef struct packed {
        logic [AluOpBusW-1:0]   aluop;
        logic [AluSelBusW-1:0]  alusel;
        logic [RegBusW-1:0]     reg1;
        logic [RegBusW-1:0]     reg2;
        logic [RegAddrBusW-1:0] wd;
        logic                   wreg;
    } stage_t;

    // Occupancy of a stage register: main empty, main only, main plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Bubble payload assembled from the individual field constants
    function automatic stage_t nop_stage();
        stage_t s;
        s.aluop  = EXE_NOP_OP;
        s.alusel = EXE_RES_NOP;
        s.reg1   = ZeroWord;
        s.reg2   = ZeroWord;
        s.wd     = NOPRegAddr;
        s.wreg   = WriteDisable;
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for stall accounting.
// Count visible one cycle after the inc cycle.
// No handshake; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count requested cycles, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, NOP bubble output and stall counter.
// One cycle from accept to out_data; full throughput with out_ready held high.
// SKID=1: two-entry skid buffer, in_ready from a flop; SKID=0: single entry, in_ready combinational.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W    = STAGE_W,
    parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
    parameter int                 SKID      = 1,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic stall_inc;

    // A stall cycle is a valid payload that downstream refuses
    assign stall_inc = out_valid && !out_ready;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    generate
        if (SKID != 0) begin : g_skid
            state_t            state;
            logic [DATA_W-1:0] main_q;
            logic [DATA_W-1:0] skid_q;
            logic              ready_q;
            logic              accept;
            logic              consume;

            assign accept   = in_valid && ready_q;
            assign consume  = (state != EMPTY) && out_ready;
            assign in_ready = ready_q;
            assign out_valid = (state != EMPTY);
            // main_q is parked at NOP_VALUE whenever empty, so out_data is a pure flop output
            assign out_data = main_q;

            // Occupancy FSM; ready_q is precomputed so upstream never sees a combinational path from out_ready
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state   <= EMPTY;
                    main_q  <= NOP_VALUE;
                    skid_q  <= NOP_VALUE;
                    ready_q <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                main_q <= in_data;
                                state  <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && consume) begin
                                main_q <= in_data;
                            end else if (accept) begin
                                skid_q  <= in_data;
                                state   <= FULL;
                                ready_q <= 1'b0;
                            end else if (consume) begin
                                main_q <= NOP_VALUE;
                                state  <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (consume) begin
                                main_q  <= skid_q;
                                skid_q  <= NOP_VALUE;
                                state   <= ONE;
                                ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= EMPTY;
                            main_q  <= NOP_VALUE;
                            skid_q  <= NOP_VALUE;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            state_t            state;
            logic [DATA_W-1:0] main_q;
            logic              accept;

            assign in_ready  = (state == EMPTY) || out_ready;
            assign accept    = in_valid && in_ready;
            assign out_valid = (state != EMPTY);
            assign out_data  = main_q;

            // Single-entry register: reload on every accept, drop to a bubble when drained
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    state  <= EMPTY;
                    main_q <= NOP_VALUE;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                main_q <= in_data;
                                state  <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept) begin
                                main_q <= in_data;
                            end else if (out_ready) begin
                                main_q <= NOP_VALUE;
                                state  <= EMPTY;
                            end
                        end
                        default: begin
                            state  <= EMPTY;
                            main_q <= NOP_VALUE;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DW = 81;
    localparam logic [DW-1:0] NOP = '0;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1;
    logic [DW-1:0] out_data1;
    logic [15:0]   stall1;

    logic          in_ready0, out_valid0;
    logic [DW-1:0] out_data0;
    logic [15:0]   stall0;

    logic          in_ready_s, out_valid_s;
    logic [DW-1:0] out_data_s;
    logic [3:0]    stall_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .stall_cnt(stall1));

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .stall_cnt(stall0));

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .SKID(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .stall_cnt(stall_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 81'h1_2345; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid1); end
        checks++; if (out_data1 !== NOP) begin errors++; $display("FAIL reset_out_data got=%h exp=%h", out_data1, NOP); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_skid got=%0b exp=1", in_ready1); end
        checks++; if (stall1 !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall1); end
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_noskid got=%0b exp=1", in_ready0); end
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== NOP) begin errors++; $display("FAIL reset_noskid_out got=%0b/%h exp=0/%h", out_valid0, out_data0, NOP); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            #1;
            checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got=%0b/%0b exp=1/1", i, in_ready1, in_ready0); end
            tick();
            checks++; if (out_valid1 !== 1'b1 || out_data1 !== DW'(i)) begin errors++; $display("FAIL stream_skid[%0d] got=%0b/%h exp=1/%h", i, out_valid1, out_data1, DW'(i)); end
            checks++; if (out_valid0 !== 1'b1 || out_data0 !== DW'(i)) begin errors++; $display("FAIL stream_noskid[%0d] got=%0b/%h exp=1/%h", i, out_valid0, out_data0, DW'(i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin errors++; $display("FAIL stream_drain_skid got=%0b/%h exp=0/%h", out_valid1, out_data1, NOP); end
        checks++; if (out_valid0 !== 1'b0 || out_data0 !== NOP) begin errors++; $display("FAIL stream_drain_noskid got=%0b/%h exp=0/%h", out_valid0, out_data0, NOP); end
        checks++; if (out_data_s !== NOP) begin errors++; $display("FAIL stream_drain_sat_inst got=%h exp=%h", out_data_s, NOP); end
    endtask

    task automatic test_back_to_back();
        // A
        out_ready = 1'b1; in_valid = 1'b1; in_data = 81'hA;
        tick();
        // B with downstream stalled
        out_ready = 1'b0; in_data = 81'hB;
        #1;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL bp_ready_before_b got=%0b exp=1", in_ready1); end
        tick();
        checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL bp_ready_after_b got=%0b exp=0", in_ready1); end
        checks++; if (out_data1 !== 81'hA || stall1 !== 16'd1) begin errors++; $display("FAIL bp_hold_1 got=%h/%0d exp=a/1", out_data1, stall1); end
        // C presented but held upstream
        in_data = 81'hC;
        tick();
        checks++; if (in_ready1 !== 1'b0 || out_data1 !== 81'hA || stall1 !== 16'd2) begin errors++; $display("FAIL bp_hold_2 got=%0b/%h/%0d exp=0/a/2", in_ready1, out_data1, stall1); end
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 81'hA || stall1 !== 16'd3) begin errors++; $display("FAIL bp_hold_3 got=%0b/%h/%0d exp=1/a/3", out_valid1, out_data1, stall1); end
        // release
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 81'hB || in_ready1 !== 1'b1) begin errors++; $display("FAIL bp_release_b got=%0b/%h/%0b exp=1/b/1", out_valid1, out_data1, in_ready1); end
        checks++; if (stall1 !== 16'd3) begin errors++; $display("FAIL bp_stall_after_release got=%0d exp=3", stall1); end
        tick();
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 81'hC) begin errors++; $display("FAIL bp_release_c got=%0b/%h exp=1/c", out_valid1, out_data1); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin errors++; $display("FAIL bp_drain got=%0b/%h exp=0/%h", out_valid1, out_data1, NOP); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 81'hE;
        tick();
        in_data = 81'hF;
        tick();
        checks++; if (in_ready1 !== 1'b0 || stall1 !== 16'd4) begin errors++; $display("FAIL flush_setup_full got=%0b/%0d exp=0/4", in_ready1, stall1); end
        // flush with D on the input; downstream consumes E this cycle
        flush = 1'b1; out_ready = 1'b1; in_data = 81'hD;
        tick();
        flush = 1'b0;
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin errors++; $display("FAIL flush_out got=%0b/%h exp=0/%h", out_valid1, out_data1, NOP); end
        checks++; if (stall1 !== 16'd4) begin errors++; $display("FAIL flush_stall_cnt got=%0d exp=4", stall1); end
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready1); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== NOP) begin errors++; $display("FAIL flush_no_d got=%0b/%h exp=0/%h", out_valid1, out_data1, NOP); end
    endtask

    task automatic test_saturation();
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 81'h6;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (stall_s !== 4'd15) begin errors++; $display("FAIL sat_reach_max got=%0d exp=15", stall_s); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stall_s !== 4'd15) begin errors++; $display("FAIL sat_no_wrap got=%0d exp=15", stall_s); end
        checks++; if (stall1 !== 16'd20) begin errors++; $display("FAIL sat_wide_count got=%0d exp=20", stall1); end
        checks++; if (out_valid_s !== 1'b1 || out_data_s !== 81'h6) begin errors++; $display("FAIL sat_hold_data got=%0b/%h exp=1/6", out_valid_s, out_data_s); end
    endtask

    task automatic test_priority();
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 81'h7; out_ready = 1'b0;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid1 !== 1'b0 || out_data1 !== NOP || in_ready1 !== 1'b1) begin errors++; $display("FAIL prio_outputs got=%0b/%h/%0b exp=0/%h/1", out_valid1, out_data1, in_ready1, NOP); end
        checks++; if (stall1 !== 16'd0) begin errors++; $display("FAIL prio_stall_cnt got=%0d exp=0", stall1); end
        checks++; if (stall_s !== 4'd0) begin errors++; $display("FAIL prio_stall_cnt_sat got=%0d exp=0", stall_s); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush_full();
        test_saturation();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
